// File: rtl/oled_spi_stream.sv
// OLED panel bring-up and SPI byte streamer.
// Drives the panel reset pulse and post-reset wait, then drains a 9-bit FIFO
// ({dc, byte}) onto a mode-0 SPI link, MSB first, keeping CS low across
// back-to-back bytes and inserting an idle gap once the FIFO runs dry.
module oled_spi_stream #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RST_CYCLES = 250000
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          reinit,
  input  logic                          wr_en,
  input  logic [8:0]                    wr_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ready,
  output logic                          busy,
  output logic                          oled_rst_n_out,
  output logic                          oled_cs_n_out,
  output logic                          oled_dc_out,
  output logic                          oled_clk_out,
  output logic                          oled_data_out
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntMax = (RST_CYCLES > CLK_DIV) ? RST_CYCLES : CLK_DIV;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] RstLast  = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] DivLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV / 2 - 1);
  localparam logic [AW:0]     FullCnt  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StRstLo,
    StRstWait,
    StIdle,
    StShift,
    StGap
  } state_e;

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [8:0]    head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FullCnt);
  assign fifo_count = count_q;
  assign head       = mem_q[rd_ptr_q];

  // A push into a full FIFO is still taken when the same cycle pops, since the
  // slot being written is the one being read out on this edge.
  assign push = wr_en && !reinit && (!fifo_full || pop);

  // Storage array: write-only on accepted pushes, no reset needed.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (reinit) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            cs_n_q, cs_n_d;
  logic            sck_q, sck_d;
  logic            dc_q, dc_d;
  logic            rst_out_q, rst_out_d;
  logic            ready_q, ready_d;
  logic            load;

  // Next-state logic: reinit overrides everything, otherwise per-state sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    dc_d      = dc_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    load      = 1'b0;
    pop       = 1'b0;

    if (reinit) begin
      state_d   = StRstLo;
      cnt_d     = '0;
      bit_d     = '0;
      sh_d      = '0;
      cs_n_d    = 1'b1;
      sck_d     = 1'b0;
      dc_d      = 1'b0;
      rst_out_d = 1'b0;
      ready_d   = 1'b0;
    end else begin
      unique case (state_q)
        StRstLo: begin
          rst_out_d = 1'b0;
          if (cnt_q == RstLast) begin
            state_d   = StRstWait;
            cnt_d     = '0;
            rst_out_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StRstWait: begin
          if (cnt_q == RstLast) begin
            state_d = StIdle;
            cnt_d   = '0;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StIdle: begin
          if (ready_q && !fifo_empty) begin
            load = 1'b1;
          end
        end

        StShift: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HalfLast) begin
            sck_d = 1'b1;
          end
          if (cnt_q == DivLast) begin
            // End of a high half: next bit starts with SCK low.
            cnt_d = '0;
            sck_d = 1'b0;
            sh_d  = {sh_q[6:0], 1'b0};
            if (bit_q != 3'd7) begin
              bit_d = bit_q + 3'd1;
            end else if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = StGap;
              cs_n_d  = 1'b1;
            end
          end
        end

        StGap: begin
          if (cnt_q == DivLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = StRstLo;
          cnt_d   = '0;
        end
      endcase

      // Start a new byte from the FIFO head; MSB is presented immediately.
      if (load) begin
        pop     = 1'b1;
        state_d = StShift;
        cnt_d   = '0;
        bit_d   = '0;
        sh_d    = head[7:0];
        dc_d    = head[8];
        cs_n_d  = 1'b0;
        sck_d   = 1'b0;
      end
    end
  end

  // Sequencer state and registered panel outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StRstLo;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      dc_q      <= 1'b0;
      rst_out_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      dc_q      <= dc_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign ready          = ready_q;
  assign busy           = (state_q != StIdle) || !fifo_empty;
  assign oled_rst_n_out = rst_out_q;
  assign oled_cs_n_out  = cs_n_q;
  assign oled_dc_out    = dc_q;
  assign oled_clk_out   = sck_q;
  assign oled_data_out  = sh_q[7];

endmodule

// File: doc/oled_spi_stream.md
OLED_SPI_STREAM -- requirements
Module: oled_spi_stream

Interface
REQ-001 Parameter CLK_DIV, default 4, means clk_in cycles per SCK period; it SHALL be even and >= 2.
REQ-002 Parameter FIFO_DEPTH, default 16, means the entry count of the byte FIFO; it SHALL be a power of 2 and >= 2.
REQ-003 Parameter RST_CYCLES, default 250000, means the panel reset low time and the post-reset wait, each in clk_in cycles (10 ms at 25 MHz).
REQ-004 Port clk_in, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port reinit, input, 1 bit: single-cycle request to restart the panel reset sequence.
REQ-007 Port wr_en, input, 1 bit: push request for wr_data.
REQ-008 Port wr_data, input, 9 bits: bit 8 is DC (0 = command, 1 = data); bits 7:0 are the byte.
REQ-009 Port fifo_full, output, 1 bit: the FIFO holds FIFO_DEPTH entries.
REQ-010 Port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-011 Port ready, output, 1 bit: the reset sequence is complete and streaming is enabled.
REQ-012 Port busy, output, 1 bit: the block is not in IDLE, or the FIFO is non-empty.
REQ-013 Port oled_rst_n_out, output, 1 bit: panel reset, active-low.
REQ-014 Port oled_cs_n_out, output, 1 bit: SPI chip select, active-low.
REQ-015 Port oled_dc_out, output, 1 bit: panel DC line.
REQ-016 Port oled_clk_out, output, 1 bit: SCK, SPI mode 0.
REQ-017 Port oled_data_out, output, 1 bit: MOSI, MSB first.

Function
REQ-018 States SHALL be: RST_LO, RST_WAIT, IDLE, SHIFT, GAP.
- RST_LO: oled_rst_n_out=0 for RST_CYCLES cycles, then go to RST_WAIT.
- RST_WAIT: oled_rst_n_out=1 for RST_CYCLES cycles, then go to IDLE and set ready=1.
REQ-019 FIFO push SHALL occur when wr_en=1 and the FIFO is not full.
- wr_en while full SHALL be dropped silently, with no corruption and no count change.
- Pushes SHALL be accepted in every state, including RST_LO and RST_WAIT.
REQ-020 Push and pop in the same cycle SHALL leave fifo_count unchanged, including when the FIFO is full; the write pointer and read pointer SHALL wrap modulo FIFO_DEPTH.
REQ-021 Pop from IDLE: in IDLE with the FIFO non-empty, the block SHALL pop the head entry.
- Next cycle: oled_cs_n_out=0, oled_dc_out=entry bit 8, oled_data_out=entry bit 7, state SHIFT.
- A wr_en at cycle T into an empty FIFO in IDLE SHALL give oled_cs_n_out=0 at T+2.
REQ-022 Each bit SHALL take CLK_DIV/2 cycles with SCK low, then CLK_DIV/2 cycles with SCK high.
- MOSI SHALL change only at the start of a low half.
- A byte SHALL take exactly 8*CLK_DIV cycles.
REQ-023 Back-to-back bytes: at the end of the 8th high half, if the FIFO is non-empty, the block SHALL pop the next entry with no extra cycles.
- oled_cs_n_out SHALL stay 0.
- oled_dc_out and MOSI SHALL update at the start of the next low half.
REQ-024 Stream end: at the end of the 8th high half, if the FIFO is empty, the block SHALL go to GAP.
- oled_cs_n_out=1 and SCK=0 for CLK_DIV cycles, then IDLE.
REQ-025 When oled_cs_n_out=1, oled_clk_out SHALL be 0.
REQ-026 reinit=1 in any state SHALL, on the next cycle, do all of the following.
- Abort any byte in progress and flush the FIFO.
- oled_cs_n_out=1, oled_clk_out=0, ready=0, state RST_LO with its counter cleared.
- A wr_en in the same cycle as reinit SHALL be discarded.
REQ-027 Any pop SHALL be made only when ready=1.

Reset
REQ-028 rst_n_in=0 SHALL asynchronously set the following.
- State RST_LO, all counters 0, FIFO empty.
- ready=0, busy=1.
- oled_rst_n_out=0, oled_cs_n_out=1, oled_dc_out=0, oled_clk_out=0, oled_data_out=0.
REQ-029 Deassertion of rst_n_in SHALL start the RST_LO count on the first following clk_in edge.
REQ-030 rst_n_in asserted mid-byte SHALL truncate the SPI frame immediately, with CS high and no partial-byte resume.

Verification (CLK_DIV=4, FIFO_DEPTH=4, RST_CYCLES=8)
REQ-031 Release rst_n_in -> oled_rst_n_out low for 8 cycles, high thereafter; ready rises 8 cycles after oled_rst_n_out rises.
REQ-032 After ready, push 0x0A5 -> CS low 2 cycles later.
- DC=0; MOSI 1,0,1,0,0,1,0,1 sampled on 8 SCK rises, with a period of 4 cycles.
- CS high after 32 cycles for 4 cycles; busy falls afterwards.
REQ-033 Push 0x1FF then 0x000 consecutively -> one continuous CS-low window of 64 cycles.
- DC=1 for the first byte, DC=0 for the second.
- No SCK gap between the bytes.
REQ-034 Push 6 entries in 6 cycles during RST_WAIT -> fifo_full=1 and fifo_count=4.
- Entries 5 and 6 are dropped.
- After ready, exactly the first 4 bytes are transmitted in order.
REQ-035 Full FIFO with a simultaneous pop and push -> fifo_count stays 4; the pushed byte is transmitted after the 3 earlier queued bytes.
REQ-036 reinit pulse during bit 3 of a byte -> next cycle CS=1, SCK=0, ready=0, fifo_count=0, oled_rst_n_out=0; the full reset sequence repeats.
